// File: rtl/sha256_drv_pkg.sv
// Shared types and constants for the SHA256 host-side block driver.
package sha256_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_SOC  = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_READ = 3'd5
  } drv_state_t;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int DIGEST_WORDS    = 8;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/sha256_host_driver_if.sv
// Block interface between the host driver and the SHA256 core.
// The driver owns soc/rd and the outgoing half of the shared data bus;
// the core returns eoc and the bus value it drives during digest reads.
interface sha256_host_driver_if;
  logic        core_soc;
  logic        core_rd;
  logic [31:0] core_data_out;
  logic        core_data_oe;
  logic [31:0] core_data_in;
  logic        core_eoc;

  modport master (
    output core_soc,
    output core_rd,
    output core_data_out,
    output core_data_oe,
    input  core_data_in,
    input  core_eoc
  );

  modport slave (
    input  core_soc,
    input  core_rd,
    input  core_data_out,
    input  core_data_oe,
    output core_data_in,
    output core_eoc
  );
endinterface

// File: rtl/sha256_blk_buf.sv
// 16x32 message block buffer: one write port filled from the upstream
// stream, one asynchronous read port used while streaming into the core.
module sha256_blk_buf
  import sha256_drv_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [WORDS_PER_BLOCK];

  // Write port: one word per accepted upstream handshake.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_host_driver.sv
// Host-side initiator for the SHA256 core block interface. Buffers each
// pre-padded 512-bit block from the upstream stream, pulses soc, streams
// the 16 words onto the core bus, waits for a fresh eoc, and after the
// last block reads the 8 digest words back and presents them downstream.
module sha256_host_driver
  import sha256_drv_pkg::*;
#(
  parameter int NBLK_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NBLK_W-1:0]     nblocks,
  input  logic [31:0]           word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  sha256_host_driver_if.master  core,
  output logic [31:0]           digest_word,
  output logic [2:0]            digest_idx,
  output logic                  digest_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  // One extra bit so the counter can reach TIMEOUT without wrapping.
  localparam int TW = $clog2(TIMEOUT + 2);

  drv_state_t        state;
  logic [3:0]        wcnt;
  logic [4:0]        scnt;
  logic [2:0]        rcnt;
  logic [TW-1:0]     tcnt;
  logic [NBLK_W-1:0] blk_rem;
  logic              armed;

  logic              soc_pulse;
  logic              rd_en;
  logic [31:0]       drive_word;
  logic              drive_en;
  logic [31:0]       dig_word;
  logic [2:0]        dig_idx;
  logic              dig_valid;
  logic              done_pulse;
  logic              err_flag;

  logic              buf_we;
  logic [31:0]       buf_rdata;

  assign buf_we = (state == ST_FILL) && word_valid;

  sha256_blk_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wcnt),
    .wdata (word_in),
    .raddr (scnt[3:0]),
    .rdata (buf_rdata)
  );

  // Main sequencer: state, counters and every registered core/host output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      scnt       <= '0;
      rcnt       <= '0;
      tcnt       <= '0;
      blk_rem    <= '0;
      armed      <= 1'b0;
      soc_pulse  <= 1'b0;
      rd_en      <= 1'b0;
      drive_word <= '0;
      drive_en   <= 1'b0;
      dig_word   <= '0;
      dig_idx    <= '0;
      dig_valid  <= 1'b0;
      done_pulse <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      soc_pulse  <= 1'b0;
      dig_valid  <= 1'b0;
      done_pulse <= 1'b0;

      // An eoc low seen any time after soc proves the next high is fresh.
      if ((state == ST_SOC || state == ST_SEND || state == ST_WAIT) && !core.core_eoc) begin
        armed <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start && (nblocks != '0)) begin
            blk_rem  <= nblocks;
            err_flag <= 1'b0;
            wcnt     <= '0;
            state    <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (word_valid) begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'(WORDS_PER_BLOCK - 1)) begin
              soc_pulse <= 1'b1;
              armed     <= 1'b0;
              scnt      <= '0;
              state     <= ST_SOC;
            end
          end
        end

        ST_SOC: begin
          drive_en   <= 1'b1;
          drive_word <= buf_rdata;
          scnt       <= 5'd1;
          state      <= ST_SEND;
        end

        // scnt 1..16: word scnt-1 on the bus; 17: bus released.
        ST_SEND: begin
          if (scnt < 5'(WORDS_PER_BLOCK)) begin
            drive_word <= buf_rdata;
            scnt       <= scnt + 5'd1;
          end else if (scnt == 5'(WORDS_PER_BLOCK)) begin
            drive_en   <= 1'b0;
            drive_word <= '0;
            scnt       <= scnt + 5'd1;
          end else begin
            tcnt  <= '0;
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (armed && core.core_eoc) begin
            blk_rem <= blk_rem - NBLK_W'(1);
            if (blk_rem == NBLK_W'(1)) begin
              rd_en <= 1'b1;
              rcnt  <= '0;
              state <= ST_READ;
            end else begin
              wcnt  <= '0;
              state <= ST_FILL;
            end
          end else if (tcnt == TW'(TIMEOUT)) begin
            err_flag   <= 1'b1;
            done_pulse <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        // Core presents H[rcnt] while rd is high; it is shown one cycle later.
        ST_READ: begin
          dig_word  <= core.core_data_in;
          dig_idx   <= rcnt;
          dig_valid <= 1'b1;
          rcnt      <= rcnt + 3'd1;
          if (rcnt == 3'(DIGEST_WORDS - 1)) begin
            rd_en      <= 1'b0;
            done_pulse <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        default: begin
          drive_en <= 1'b0;
          rd_en    <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign word_ready = (state == ST_FILL);

  assign core.core_soc      = soc_pulse;
  assign core.core_rd       = rd_en;
  assign core.core_data_out = drive_word;
  assign core.core_data_oe  = drive_en;

  assign digest_word  = dig_word;
  assign digest_idx   = dig_idx;
  assign digest_valid = dig_valid;
  assign done         = done_pulse;
  assign err_timeout  = err_flag;

endmodule
